// File: rtl/enc_pkg.sv
// Shared types and constants for the quadrature encoder front end.
package enc_pkg;

    localparam int DEFAULT_WIDTH           = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Wide enough for any legal debounce length (1..65535).
    localparam int CNT_W = 16;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        INIT,
        TRACK
    } state_e;

    // Next phase pair, packed as {b, a}, when moving in the up direction.
    function automatic logic [1:0] gray_up(input logic [1:0] ba);
        case (ba)
            2'b00:   gray_up = 2'b01;
            2'b01:   gray_up = 2'b11;
            2'b11:   gray_up = 2'b10;
            default: gray_up = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/enc_frontend_if.sv
// Encoder front end signal bundle: raw phases and clear in, position and step events out.
interface enc_frontend_if #(
    parameter int WIDTH = enc_pkg::DEFAULT_WIDTH
);
    logic             enc_a;
    logic             enc_b;
    logic             clear;
    logic [WIDTH-1:0] value;
    logic             step_valid;
    logic             step_dir;
    logic             err;

    modport master (
        output enc_a, enc_b, clear,
        input  value, step_valid, step_dir, err
    );

    modport slave (
        input  enc_a, enc_b, clear,
        output value, step_valid, step_dir, err
    );
endinterface

// File: rtl/enc_debounce.sv
// One encoder phase: two-flop synchronizer followed by a consecutive-cycle debounce filter.
module enc_debounce
    import enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic filt_o,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shift the raw pin through the synchronizer and count consecutive disagreeing edges.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sync_d = {sync_q[0], raw_i};
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == LAST) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample together.
        if (!reset_n) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o   = filt_q;
    assign stable_o = (sync_q[0] == sync_q[1]) && (sync_q[1] == filt_q);

endmodule

// File: rtl/enc_frontend.sv
// Quadrature encoder front end: debounced phases, x4 Gray decode, position counter.
// Build option: define ENC_SATURATE_EN to make the position clamp at its limits
// instead of wrapping.
module enc_frontend
    import enc_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input logic           clk,
    input logic           reset_n,
    enc_frontend_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             filt_a, filt_b, stable_a, stable_b;
    logic [1:0]       pair_now;

    state_e           state_q, state_d;
    logic [1:0]       pair_q, pair_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             warm_q, warm_d;
    logic [WIDTH-1:0] value_q, value_d, value_inc, value_dec;
    logic             step_valid_q, step_valid_d;
    logic             step_dir_q, step_dir_d;
    logic             err_q, err_d;

    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_i    (bus.enc_a),
        .filt_o   (filt_a),
        .stable_o (stable_a)
    );

    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_i    (bus.enc_b),
        .filt_o   (filt_b),
        .stable_o (stable_b)
    );

    assign pair_now = {filt_b, filt_a};

`ifdef ENC_SATURATE_EN
    assign value_inc = (value_q == '1) ? value_q : value_q + 1'b1;
    assign value_dec = (value_q == '0) ? value_q : value_q - 1'b1;
`else
    assign value_inc = value_q + 1'b1;
    assign value_dec = value_q - 1'b1;
`endif

    // Settle in INIT, then decode filtered pair changes into steps; clear overrides the count.
    always_comb begin
        state_d      = state_q;
        pair_d       = pair_now;
        settle_d     = settle_q;
        warm_d       = 1'b1;
        value_d      = value_q;
        step_valid_d = 1'b0;
        step_dir_d   = step_dir_q;
        err_d        = err_q;

        case (state_q)
            INIT: begin
                // warm_q keeps the pre-reset zeros in the synchronizer from counting as settled.
                if (warm_q && stable_a && stable_b) begin
                    if (settle_q == LAST) begin
                        state_d  = TRACK;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end else begin
                    settle_d = '0;
                end
            end
            TRACK: begin
                if ((pair_now ^ pair_q) == 2'b11) begin
                    err_d = 1'b1;
                end else if (pair_now != pair_q) begin
                    step_valid_d = 1'b1;
                    if (pair_now == gray_up(pair_q)) begin
                        step_dir_d = DIR_UP;
                        value_d    = value_inc;
                    end else begin
                        step_dir_d = DIR_DOWN;
                        value_d    = value_dec;
                    end
                end
            end
            default: state_d = INIT;
        endcase

        if (bus.clear) begin
            value_d = '0;
            err_d   = 1'b0;
        end
    end

    // FSM and output registers; outputs come straight from flops so reset shows immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= INIT;
            pair_q       <= '0;
            settle_q     <= '0;
            warm_q       <= 1'b0;
            value_q      <= '0;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pair_q       <= pair_d;
            settle_q     <= settle_d;
            warm_q       <= warm_d;
            value_q      <= value_d;
            step_valid_q <= step_valid_d;
            step_dir_q   <= step_dir_d;
            err_q        <= err_d;
        end
    end

    assign bus.value      = value_q;
    assign bus.step_valid = step_valid_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.err        = err_q;

endmodule

// File: doc/enc_frontend.md
ENC_FRONTEND -- requirements
Module: enc_frontend

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bit width of position value.
REQ-002 SHALL have parameter: DEBOUNCE_CYCLES, 16, consecutive stable clocks required before a filtered input changes (legal range 1..65535).
REQ-003 SHALL have port: clk  input  1  single clock, rising-edge; the only clock.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port: enc_a  input  1  encoder phase A, asynchronous to clk, may bounce.
REQ-006 SHALL have port: enc_b  input  1  encoder phase B, asynchronous to clk, may bounce.
REQ-007 SHALL have port: clear  input  1  synchronous, zeroes value and err.
REQ-008 SHALL have port: value  output  WIDTH  current position count, consumed by the PWM mixer stage.
REQ-009 SHALL have port: step_valid  output  1  one-cycle pulse per accepted quadrature step.
REQ-010 SHALL have port: step_dir  output  1  direction of last step: 1 = up (A leads B), 0 = down; valid while step_valid is high.
REQ-011 SHALL have port: err  output  1  sticky flag, illegal transition (both phases changed on one edge).

Function
REQ-012 SHALL pass each of enc_a/enc_b through a 2-flop synchronizer, then an independent debounce counter.
REQ-013 Debounce: counter increments on each edge where synchronized level differs from filtered level, resets to 0 on any edge where they match; filtered level takes new value on the DEBOUNCE_CYCLES-th consecutive differing edge.
REQ-014 Latency: raw level stable from edge 1 -> filtered updates at edge DEBOUNCE_CYCLES+2 -> value/step_valid update at edge DEBOUNCE_CYCLES+3.
REQ-015 FSM states: INIT, TRACK. INIT entered on reset; in INIT the filtered pair is loaded from the synchronized pair once both have been unchanged for DEBOUNCE_CYCLES consecutive edges, then -> TRACK with no step, no value change.
REQ-016 TRACK decode, Gray sequence 00->01->11->10->00 (BA) = up, reverse = down; each valid single-bit filtered change produces exactly one step (x4 decode).
REQ-017 Up step: value+1; down step: value-1; arithmetic modulo 2^WIDTH unless REQ-024 applies.
REQ-018 Both filtered bits changing on the same edge: err set, no step, value unchanged, filtered pair still updated.
REQ-019 clear and step on same edge: value = 0, err = 0, step_valid still pulses with correct step_dir.
REQ-020 step_valid SHALL never be high on two consecutive cycles when DEBOUNCE_CYCLES >= 2.

Reset
REQ-021 On reset_n low: value = 0, step_valid = 0, step_dir = 0, err = 0, synchronizers/filtered/counters = 0, FSM = INIT; outputs valid immediately.
REQ-022 Reset asserted mid-debounce or mid-step SHALL discard partial state; no step emitted after release until INIT completes.
REQ-023 Reset deassertion SHALL be synchronous to clk at the integration level; block itself needs no internal reset synchronizer.

Configuration
REQ-024 Macro ENC_SATURATE_EN: when defined, value saturates (up at 2^WIDTH-1 holds, down at 0 holds, step_valid still pulses); when undefined, value wraps (0xFF+1 -> 0x00, 0x00-1 -> 0xFF for WIDTH=8).

Structure
REQ-025 Package enc_pkg SHALL hold: FSM state enum (INIT, TRACK), direction constants DIR_UP=1/DIR_DOWN=0, default WIDTH and DEBOUNCE_CYCLES constants.
REQ-026 Sub-module enc_debounce (synchronizer + debounce counter, one input) SHALL be instantiated twice; decode, FSM and counter live in enc_frontend.

Verification
REQ-027 Reset with A=B=1 held, DEBOUNCE_CYCLES=4 -> INIT exits after settling, value=0, no step_valid, err=0.
REQ-028 Four clean up transitions 00->01->11->10->00, each held 10 cycles -> value=4, four step_valid pulses with step_dir=1, each DEBOUNCE_CYCLES+3 edges after raw change.
REQ-029 Glitch on enc_a of DEBOUNCE_CYCLES-1 cycles -> no filtered change, value unchanged, no step_valid.
REQ-030 A and B toggled on same raw edge from 00 to 11 -> err=1, value unchanged; then clear=1 one cycle -> err=0, value=0.
REQ-031 From value=0 one down step -> value=0xFF without ENC_SATURATE_EN, value=0x00 with it; from 0xFF one up step -> 0x00 / 0xFF respectively.
REQ-032 reset_n pulsed low mid-debounce (counter=2 of 4) -> all outputs 0 asynchronously, no step emitted for the interrupted transition.
